// File: rtl/serv_aligner_buf.sv
// Instruction-fetch aligner with a one-word reuse buffer between the SERV ibus and Wishbone memory.
// Define SERV_ALIGNER_STATS_EN to add saturating hit / bus-ack counters (o_hit_cnt, o_bus_cnt).
module serv_aligner_buf #(
    parameter int AW            = 32,
    parameter int REUSE_ALIGNED = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     i_ibus_adr,
    input  logic              i_ibus_cyc,
    output logic [31:0]       o_ibus_rdt,
    output logic              o_ibus_ack,
    output logic [AW-1:0]     o_wb_ibus_adr,
    output logic              o_wb_ibus_cyc,
    input  logic [31:0]       i_wb_ibus_rdt,
    input  logic              i_wb_ibus_ack,
    input  logic              i_flush
`ifdef SERV_ALIGNER_STATS_EN
    ,
    output logic [CNT_W-1:0]  o_hit_cnt,
    output logic [CNT_W-1:0]  o_bus_cnt
`endif
);

    localparam int   WW    = AW - 2;
    localparam logic REUSE = (REUSE_ALIGNED != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state_reg;
    logic [WW-1:0]   w_reg;
    logic            mis_reg;
    logic [15:0]     lo_hw_reg;

    logic [31:0]     hold_word_reg;
    logic [WW-1:0]   hold_tag_reg;
    logic            hold_vld_reg;

    logic [WW-1:0]   w1;
    logic [WW-1:0]   acc_word;
    logic [WW-1:0]   acc_word1;
    logic            acc_hit;
    logic            acc_fast;
    logic            acc_skip_lo;
    logic            in_req;
    logic            bus_ack;
    logic [WW-1:0]   buf_tag;

    // Byte-offset bit 0 is always zero for a halfword-aligned fetch.
    logic            unused_adr0;
    assign unused_adr0 = i_ibus_adr[0];

    assign w1          = w_reg + WW'(1);
    assign acc_word    = i_ibus_adr[AW-1:2];
    assign acc_word1   = acc_word + WW'(1);
    assign acc_hit     = hold_vld_reg && (hold_tag_reg == acc_word);
    assign acc_fast    = acc_hit && !i_ibus_adr[1] && REUSE;
    assign acc_skip_lo = acc_hit && i_ibus_adr[1];
    assign in_req      = (state_reg == REQ_LO) || (state_reg == REQ_HI);
    assign bus_ack     = in_req && i_wb_ibus_ack;
    assign buf_tag     = (state_reg == REQ_HI) ? w1 : w_reg;

    // Every completed memory read refills the buffer, even one that lands in an abort cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_word_reg <= '0;
            hold_tag_reg  <= '0;
            hold_vld_reg  <= 1'b0;
        end else begin
            if (bus_ack) begin
                hold_word_reg <= i_wb_ibus_rdt;
                hold_tag_reg  <= buf_tag;
                hold_vld_reg  <= 1'b1;
            end
            if (i_flush) begin
                hold_vld_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            w_reg         <= '0;
            mis_reg       <= 1'b0;
            lo_hw_reg     <= '0;
            o_ibus_rdt    <= '0;
            o_ibus_ack    <= 1'b0;
            o_wb_ibus_adr <= '0;
            o_wb_ibus_cyc <= 1'b0;
        end else begin
            o_ibus_ack <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_ibus_cyc) begin
                        w_reg   <= acc_word;
                        mis_reg <= i_ibus_adr[1];
                        if (acc_fast) begin
                            o_ibus_rdt <= hold_word_reg;
                            o_ibus_ack <= 1'b1;
                            state_reg  <= RESP;
                        end else if (acc_skip_lo) begin
                            lo_hw_reg     <= hold_word_reg[31:16];
                            o_wb_ibus_adr <= {acc_word1, 2'b00};
                            o_wb_ibus_cyc <= 1'b1;
                            state_reg     <= REQ_HI;
                        end else begin
                            o_wb_ibus_adr <= {acc_word, 2'b00};
                            o_wb_ibus_cyc <= 1'b1;
                            state_reg     <= REQ_LO;
                        end
                    end
                end
                REQ_LO: begin
                    if (!i_ibus_cyc) begin
                        o_wb_ibus_cyc <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (i_wb_ibus_ack) begin
                        if (mis_reg) begin
                            // Keep the bus request up and move straight to the next word.
                            lo_hw_reg     <= i_wb_ibus_rdt[31:16];
                            o_wb_ibus_adr <= {w1, 2'b00};
                            state_reg     <= REQ_HI;
                        end else begin
                            o_ibus_rdt    <= i_wb_ibus_rdt;
                            o_ibus_ack    <= 1'b1;
                            o_wb_ibus_cyc <= 1'b0;
                            state_reg     <= RESP;
                        end
                    end
                end
                REQ_HI: begin
                    if (!i_ibus_cyc) begin
                        o_wb_ibus_cyc <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (i_wb_ibus_ack) begin
                        o_ibus_rdt    <= {i_wb_ibus_rdt[15:0], lo_hw_reg};
                        o_ibus_ack    <= 1'b1;
                        o_wb_ibus_cyc <= 1'b0;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef SERV_ALIGNER_STATS_EN
    logic                  hit_evt;
    logic [1:0]            cnt_evt;
    logic [1:0][CNT_W-1:0] cnt_all;

    assign hit_evt = (state_reg == IDLE) && i_ibus_cyc && (acc_fast || acc_skip_lo);
    assign cnt_evt = {bus_ack, hit_evt};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst || i_flush) begin
                    cnt_reg <= '0;
                end else if (cnt_evt[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    assign o_hit_cnt = cnt_all[0];
    assign o_bus_cnt = cnt_all[1];
`endif

endmodule

// File: tb/tb_serv_aligner_buf.sv
// Directed and randomized bench for serv_aligner_buf against a word-level fetch/buffer model.
module tb_serv_aligner_buf;

    localparam int REUSE = 1;

    logic        clk;
    logic        rst;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] o_wb_ibus_adr;
    logic        o_wb_ibus_cyc;
    logic [31:0] i_wb_ibus_rdt;
    logic        i_wb_ibus_ack;
    logic        i_flush;
`ifdef SERV_ALIGNER_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] bus_cnt;
`endif

    serv_aligner_buf #(
        .AW(32),
        .REUSE_ALIGNED(REUSE),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_ibus_adr(i_ibus_adr),
        .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt),
        .o_ibus_ack(o_ibus_ack),
        .o_wb_ibus_adr(o_wb_ibus_adr),
        .o_wb_ibus_cyc(o_wb_ibus_cyc),
        .i_wb_ibus_rdt(i_wb_ibus_rdt),
        .i_wb_ibus_ack(i_wb_ibus_ack),
        .i_flush(i_flush)
`ifdef SERV_ALIGNER_STATS_EN
        ,
        .o_hit_cnt(hit_cnt),
        .o_bus_cnt(bus_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory responder state and contents
    logic [31:0] mem_tab [logic [31:0]];
    logic [31:0] bus_q [$];
    logic [31:0] exp_q [$];
    int          mem_lat = 0;
    int          pend = -1;
    bit          mem_en = 1'b1;

    // Reference buffer: last word fetched from memory
    bit          m_vld = 1'b0;
    logic [29:0] m_tag = '0;
    logic [31:0] m_word = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (mem_tab.exists(a)) return mem_tab[a];
        h = a * 32'h9E37_79B1;
        return h ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, then let the memory model react.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_en) begin
            if (i_wb_ibus_ack) begin
                i_wb_ibus_ack = 1'b0;
                pend = -1;
            end
            if (o_wb_ibus_cyc) begin
                if (pend < 0) pend = mem_lat;
                if (pend == 0) begin
                    i_wb_ibus_ack = 1'b1;
                    i_wb_ibus_rdt = mem_word(o_wb_ibus_adr);
                    bus_q.push_back(o_wb_ibus_adr);
                end else begin
                    pend--;
                end
            end else begin
                pend = -1;
            end
        end
    endtask

    task automatic model_fetch(input logic [31:0] a, output logic [31:0] rdt);
        logic [29:0] w;
        logic [29:0] w1;
        logic [31:0] lo_word;
        logic [31:0] hi_word;
        logic [15:0] lo;
        w  = a[31:2];
        w1 = w + 30'd1;
        exp_q.delete();
        if (!a[1]) begin
            if (m_vld && m_tag == w && REUSE != 0) begin
                rdt = m_word;
            end else begin
                exp_q.push_back({w, 2'b00});
                rdt    = mem_word({w, 2'b00});
                m_vld  = 1'b1;
                m_tag  = w;
                m_word = rdt;
            end
        end else begin
            if (m_vld && m_tag == w) begin
                lo = m_word[31:16];
            end else begin
                exp_q.push_back({w, 2'b00});
                lo_word = mem_word({w, 2'b00});
                lo = lo_word[31:16];
            end
            exp_q.push_back({w1, 2'b00});
            hi_word = mem_word({w1, 2'b00});
            rdt    = {hi_word[15:0], lo};
            m_vld  = 1'b1;
            m_tag  = w1;
            m_word = hi_word;
        end
    endtask

    task automatic flush_buf();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        m_vld = 1'b0;
    endtask

    // flush_at >= 0 pulses i_flush on that edge of the fetch, at or after the buffer write.
    task automatic fetch(input logic [31:0] a, input int lat, input int flush_at, input string tag);
        logic [31:0] exp_rdt;
        logic [31:0] got_rdt;
        logic [31:0] obs_adr;
        int          n;
        int          exp_lat;
        bit          got;
        model_fetch(a, exp_rdt);
        if (flush_at >= 0) m_vld = 1'b0;
        exp_lat = (exp_q.size() == 0) ? 1 : 1 + exp_q.size() * (1 + lat);
        bus_q.delete();
        mem_lat = lat;
        i_ibus_adr = a;
        i_ibus_cyc = 1'b1;
        n = 0;
        got = 1'b0;
        got_rdt = '0;
        while (!got && n < 64) begin
            i_flush = (n + 1 == flush_at);
            tick();
            i_flush = 1'b0;
            n++;
            if (o_ibus_ack) begin
                got = 1'b1;
                got_rdt = o_ibus_rdt;
                i_ibus_cyc = 1'b0;
            end
        end
        i_ibus_cyc = 1'b0;
        check({tag, "_ack_seen"}, 64'(got), 64'd1);
        check({tag, "_rdt"}, 64'(got_rdt), 64'(exp_rdt));
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_bus_count"}, 64'(bus_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            obs_adr = (i < bus_q.size()) ? bus_q[i] : 32'hxxxx_xxxx;
            check({tag, "_bus_adr"}, 64'(obs_adr), 64'(exp_q[i]));
        end
        tick();
        check({tag, "_ack_pulse"}, 64'(o_ibus_ack), 64'd0);
        check({tag, "_rdt_hold"}, 64'(o_ibus_rdt), 64'(exp_rdt));
        $display("fetch %-10s adr=%08h lat=%0d rdt=%08h exp=%08h bus=%0d cycles=%0d",
                 tag, a, lat, got_rdt, exp_rdt, bus_q.size(), n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ibus_ack"}, 64'(o_ibus_ack), 64'd0);
        check({tag, "_ibus_rdt"}, 64'(o_ibus_rdt), 64'd0);
        check({tag, "_wb_cyc"}, 64'(o_wb_ibus_cyc), 64'd0);
        check({tag, "_wb_adr"}, 64'(o_wb_ibus_adr), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        bit          any_ack;

        rst = 1'b1;
        i_ibus_adr = '0;
        i_ibus_cyc = 1'b0;
        i_wb_ibus_rdt = '0;
        i_wb_ibus_ack = 1'b0;
        i_flush = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // Aligned cold fetch
        mem_tab[32'h100] = 32'h00A0_0093;
        fetch(32'h100, 1, -1, "aligned");

        // Misaligned cold fetch spanning two words
        flush_buf();
        mem_tab[32'h100] = 32'h1111_AAAA;
        mem_tab[32'h104] = 32'hBBBB_2222;
        mem_tab[32'h108] = 32'h3333_CCCC;
        fetch(32'h102, 0, -1, "mis_cold");

        // Aligned hit on buffered word, then misaligned needing only the upper word
        fetch(32'h104, 0, -1, "al_hit");
        fetch(32'h106, 1, -1, "mis_hit");

        // Same aligned word twice, then again after a flush
        fetch(32'h104, 2, -1, "reuse_a");
        fetch(32'h104, 0, -1, "reuse_b");
        flush_buf();
        fetch(32'h104, 0, -1, "flushed");

        // Flush on the same edge as the buffer write must leave it invalid
        fetch(32'h200, 0, 2, "flush_wr");
        fetch(32'h200, 0, -1, "after_fw");

        // Top word wraps to address 0
        fetch(32'hFFFF_FFFE, 1, -1, "wrap");

        // Abort while waiting in the first memory read
        flush_buf();
        bus_q.delete();
        mem_lat = 5;
        i_ibus_adr = 32'h302;
        i_ibus_cyc = 1'b1;
        tick();
        tick();
        check("abort_wb_cyc_hi", 64'(o_wb_ibus_cyc), 64'd1);
        i_ibus_cyc = 1'b0;
        tick();
        check("abort_wb_cyc_lo", 64'(o_wb_ibus_cyc), 64'd0);
        any_ack = o_ibus_ack;
        repeat (3) begin
            tick();
            any_ack = any_ack | o_ibus_ack;
        end
        check("abort_no_ack", 64'(any_ack), 64'd0);
        check("abort_no_bus", 64'(bus_q.size()), 64'd0);
        $display("abort adr=%08h ack_seen=%0d", 32'h302, any_ack);

        // Reset while waiting for the upper word, then a stray memory ack
        flush_buf();
        mem_en = 1'b0;
        i_ibus_adr = 32'h402;
        i_ibus_cyc = 1'b1;
        tick();
        i_wb_ibus_rdt = mem_word(32'h400);
        i_wb_ibus_ack = 1'b1;
        tick();
        i_wb_ibus_ack = 1'b0;
        check("rst_hi_wb_adr", 64'(o_wb_ibus_adr), 64'h404);
        check("rst_hi_wb_cyc", 64'(o_wb_ibus_cyc), 64'd1);
        tick();
        rst = 1'b1;
        i_ibus_cyc = 1'b0;
        tick();
        rst = 1'b0;
        m_vld = 1'b0;
        check_idle_outputs("rst_mid");
        i_wb_ibus_rdt = 32'hDEAD_BEEF;
        i_wb_ibus_ack = 1'b1;
        tick();
        any_ack = o_ibus_ack;
        i_wb_ibus_ack = 1'b0;
        tick();
        any_ack = any_ack | o_ibus_ack;
        check("late_ack_ignored", 64'(any_ack), 64'd0);
        check_idle_outputs("late_ack");
        $display("reset_mid_req adr=%08h ack_seen=%0d", 32'h402, any_ack);
        mem_en = 1'b1;
        pend = -1;
        fetch(32'h400, 0, -1, "post_rst");

        // Randomized fetches around a small window to mix hits, misses and flushes
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 5) == 0) flush_buf();
            if ($urandom_range(0, 3) == 0) tick();
            r = $urandom();
            if ($urandom_range(0, 7) == 0) a = {r[31:1], 1'b0};
            else a = 32'h800 + 32'($urandom_range(0, 11)) * 32'd2;
            fetch(a, int'($urandom_range(0, 2)), -1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
